// File: rtl/jtag_tap_ir_if.sv
// Pin-side and user-DR strobe bundle of the jtag_tap_ir TAP.
interface jtag_tap_ir_if #(parameter int unsigned IR_WIDTH = 4);
  logic                TMS;
  logic                TDI;
  logic                TDO;
  logic                TDO_OE;
  logic [IR_WIDTH-1:0] IR;
  logic [3:0]          STATE;
  logic                USER_SEL;
  logic                USER_CAPTURE;
  logic                USER_SHIFT;
  logic                USER_UPDATE;
  logic                USER_TDO;

  modport master (output TMS, TDI, USER_TDO,
                  input  TDO, TDO_OE, IR, STATE, USER_SEL, USER_CAPTURE, USER_SHIFT, USER_UPDATE);
  modport slave  (input  TMS, TDI, USER_TDO,
                  output TDO, TDO_OE, IR, STATE, USER_SEL, USER_CAPTURE, USER_SHIFT, USER_UPDATE);
endinterface

// File: rtl/jtag_tap_ir.sv
// 1149.1 TAP with built-in IR, BYPASS, optional IDCODE DR and gated user-DR strobes.
// Define JTAG_TAP_IDCODE_EN to build the 32-bit IDCODE register (reset instruction becomes IDCODE).
module jtag_tap_ir #(
  parameter int unsigned         IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE    = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] OP_USER      = IR_WIDTH'(2),
  parameter logic [IR_WIDTH-1:0] OP_BYPASS    = '1
) (
  input logic         TCK,
  input logic         TRST,
  jtag_tap_ir_if.slave jt
);
  typedef enum logic [3:0] {
    RTI = 4'h0, SEL_DR = 4'h1, CAP_DR = 4'h2, SH_DR = 4'h3, EX1_DR = 4'h4, PAU_DR = 4'h5,
    EX2_DR = 4'h6, UPD_DR = 4'h7, SEL_IR = 4'h8, CAP_IR = 4'h9, SH_IR = 4'hA, EX1_IR = 4'hB,
    PAU_IR = 4'hC, EX2_IR = 4'hD, UPD_IR = 4'hE, TLR = 4'hF
  } tap_state_e;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RST_IR = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RST_IR = OP_BYPASS;
`endif
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_e          state_q, state_d;
  logic                cap_ir_d, sh_ir_d, upd_ir_d, cap_dr_d, sh_dr_d, upd_dr_d, tlr_d;
  logic                cap_ir, sh_ir, cap_dr, sh_dr, upd_dr;
  logic [IR_WIDTH-1:0] ir_sr, ir_q;
  logic                bypass_q, tdo_q, tdo_oe_q;
  logic                sel_user, sel_idcode, idcode_lsb, dr_lsb;

  always_ff @(posedge TCK or negedge TRST)
    if (!TRST) state_q <= TLR;
    else       state_q <= state_d;

  always_comb begin
    state_d = TLR;
    case (state_q)
      TLR:     state_d = jt.TMS ? TLR    : RTI;
      RTI:     state_d = jt.TMS ? SEL_DR : RTI;
      SEL_DR:  state_d = jt.TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = jt.TMS ? EX1_DR : SH_DR;
      SH_DR:   state_d = jt.TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_d = jt.TMS ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = jt.TMS ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = jt.TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_d = jt.TMS ? SEL_DR : RTI;
      SEL_IR:  state_d = jt.TMS ? TLR    : CAP_IR;
      CAP_IR:  state_d = jt.TMS ? EX1_IR : SH_IR;
      SH_IR:   state_d = jt.TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_d = jt.TMS ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = jt.TMS ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = jt.TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_d = jt.TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_comb begin
    cap_ir_d = (state_q == CAP_IR);
    sh_ir_d  = (state_q == SH_IR);
    upd_ir_d = (state_q == UPD_IR);
    cap_dr_d = (state_q == CAP_DR);
    sh_dr_d  = (state_q == SH_DR);
    upd_dr_d = (state_q == UPD_DR);
    tlr_d    = (state_q == TLR);
  end

  // Strobes are sampled mid-state so the next rising edge acts on a stable decode.
  always_ff @(negedge TCK or negedge TRST)
    if (!TRST) {cap_ir, sh_ir, cap_dr, sh_dr, upd_dr} <= '0;
    else       {cap_ir, sh_ir, cap_dr, sh_dr, upd_dr} <= {cap_ir_d, sh_ir_d, cap_dr_d, sh_dr_d, upd_dr_d};

  always_ff @(negedge TCK or negedge TRST)
    if (!TRST)         ir_q <= RST_IR;
    else if (tlr_d)    ir_q <= RST_IR;
    else if (upd_ir_d) ir_q <= ir_sr;

  always_ff @(posedge TCK or negedge TRST)
    if (!TRST)       ir_sr <= '0;
    else if (cap_ir) ir_sr <= IR_CAPTURE;
    else if (sh_ir)  ir_sr <= {jt.TDI, ir_sr[IR_WIDTH-1:1]};

  assign sel_user = (ir_q == OP_USER);

  always_ff @(posedge TCK or negedge TRST)
    if (!TRST) bypass_q <= 1'b0;
    else if (!sel_user && !sel_idcode) begin
      if (cap_dr)     bypass_q <= 1'b0;
      else if (sh_dr) bypass_q <= jt.TDI;
    end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_sr;
  assign sel_idcode = !sel_user && (ir_q == OP_IDCODE);
  assign idcode_lsb = idcode_sr[0];

  always_ff @(posedge TCK or negedge TRST)
    if (!TRST) idcode_sr <= '0;
    else if (sel_idcode) begin
      if (cap_dr)     idcode_sr <= IDCODE_VALUE;
      else if (sh_dr) idcode_sr <= {jt.TDI, idcode_sr[31:1]};
    end
`else
  assign sel_idcode = 1'b0;
  assign idcode_lsb = 1'b0;
`endif

  assign dr_lsb = sel_user ? jt.USER_TDO : (sel_idcode ? idcode_lsb : bypass_q);

  // TDO keeps its last bit outside shift states; only TDO_OE drops.
  always_ff @(negedge TCK or negedge TRST)
    if (!TRST) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_oe_q <= sh_ir_d | sh_dr_d;
      if (sh_ir_d)      tdo_q <= ir_sr[0];
      else if (sh_dr_d) tdo_q <= dr_lsb;
    end

  assign jt.TDO          = tdo_q;
  assign jt.TDO_OE       = tdo_oe_q;
  assign jt.IR           = ir_q;
  assign jt.STATE        = state_q;
  assign jt.USER_SEL     = sel_user;
  assign jt.USER_CAPTURE = cap_dr & sel_user;
  assign jt.USER_SHIFT   = sh_dr  & sel_user;
  assign jt.USER_UPDATE  = upd_dr & sel_user;
endmodule

// File: tb/tb_jtag_tap_ir.sv
// Directed + randomized scans of jtag_tap_ir checked against a serial-stream model.
module tb_jtag_tap_ir;
  localparam int W = 4;
`ifdef JTAG_TAP_IDCODE_EN
  localparam bit IDC = 1'b1;
`else
  localparam bit IDC = 1'b0;
`endif
  localparam logic [W-1:0] RST_IR = IDC ? 4'h1 : 4'hF;
  localparam logic [31:0]  IDV    = 32'h1000_0001;

  logic TCK = 1'b0;
  logic TRST;
  int   total = 0, passes = 0;
  int   n_cap, n_sh, n_upd;
  logic [W-1:0] model_ir;

  jtag_tap_ir_if #(.IR_WIDTH(W)) jt();
  jtag_tap_ir dut (.TCK(TCK), .TRST(TRST), .jt(jt));

  always #10 TCK = ~TCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick(input logic tms, input logic tdi);
    jt.TMS = tms;
    jt.TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
    if (jt.USER_CAPTURE) n_cap++;
    if (jt.USER_SHIFT)   n_sh++;
    if (jt.USER_UPDATE)  n_upd++;
  endtask

  // Output stream of a scan = captured bits (LSB first) followed by the TDI bits.
  task automatic ir_scan(input logic [W-1:0] op, input int extra);
    bit d[$], s[$];
    int n;
    for (int i = 0; i < extra; i++) d.push_back(bit'($urandom_range(1, 0)));
    for (int i = 0; i < W; i++) d.push_back(op[i]);
    for (int i = 0; i < W; i++) s.push_back(i == 0);
    foreach (d[i]) s.push_back(d[i]);
    n = d.size();
    tick(1, 0); tick(1, 0); tick(0, 0);
    chk("st_capir", jt.STATE, 4'h9);
    tick(0, 0);
    for (int k = 0; k < n; k++) begin
      chk("ir_tdo", jt.TDO, s[k]);
      chk("ir_oe", jt.TDO_OE, 1'b1);
      tick(k == n - 1, d[k]);
    end
    chk("ir_ex1_oe", jt.TDO_OE, 1'b0);
    tick(1, 0);
    model_ir = op;
    chk("ir_upd", jt.IR, model_ir);
    chk("user_sel", jt.USER_SEL, model_ir == 4'h2);
    tick(0, 0);
    chk("st_rti", jt.STATE, 4'h0);
  endtask

  task automatic dr_scan(input int n, input int pause_at, input logic [63:0] data);
    bit d[$], s[$];
    bit user, idc;
    logic u;
    user = (model_ir == 4'h2);
    idc  = IDC && (model_ir == 4'h1);
    for (int i = 0; i < n; i++) d.push_back(data[i]);
    if (idc)        for (int i = 0; i < 32; i++) s.push_back(IDV[i]);
    else if (!user) s.push_back(1'b0);
    foreach (d[i]) s.push_back(d[i]);
    n_cap = 0; n_sh = 0; n_upd = 0;
    tick(1, 0); tick(0, 0);
    u = 1'($urandom); jt.USER_TDO = u;
    tick(0, 0);
    chk("st_shdr", jt.STATE, 4'h3);
    for (int k = 0; k < n; k++) begin
      chk("dr_tdo", jt.TDO, user ? u : s[k]);
      chk("dr_oe", jt.TDO_OE, 1'b1);
      if (k == pause_at && k != n - 1) begin
        tick(1, d[k]);
        chk("ex1_oe", jt.TDO_OE, 1'b0);
        tick(0, 0); tick(0, 0);
        chk("st_pause", jt.STATE, 4'h5);
        tick(1, 0);
        u = 1'($urandom); jt.USER_TDO = u;
        tick(0, 0);
      end else begin
        if (k < n - 1) begin u = 1'($urandom); jt.USER_TDO = u; end
        tick(k == n - 1, d[k]);
      end
    end
    chk("dr_ex1_oe", jt.TDO_OE, 1'b0);
    tick(1, 0); tick(0, 0);
    chk("n_cap", n_cap, user ? 1 : 0);
    chk("n_shift", n_sh, user ? n : 0);
    chk("n_upd", n_upd, user ? 1 : 0);
  endtask

  initial begin
    logic [W-1:0] op;
    int ln;
    TRST = 1'b0; jt.TMS = 1'b1; jt.TDI = 1'b0; jt.USER_TDO = 1'b0;
    n_cap = 0; n_sh = 0; n_upd = 0;
    #25;
    chk("rst_state", jt.STATE, 4'hF);
    chk("rst_ir", jt.IR, RST_IR);
    chk("rst_tdo", jt.TDO, 1'b0);
    chk("rst_oe", jt.TDO_OE, 1'b0);
    chk("rst_strobes", {jt.USER_SEL, jt.USER_CAPTURE, jt.USER_SHIFT, jt.USER_UPDATE}, 4'h0);
    @(negedge TCK); #1 TRST = 1'b1;
    tick(0, 0);
    chk("rel_state", jt.STATE, 4'h0);
    chk("rel_ir", jt.IR, RST_IR);
    chk("rel_oe", jt.TDO_OE, 1'b0);
    model_ir = RST_IR;

    dr_scan(32, -1, 64'h0);
    ir_scan(4'h2, 0);
    dr_scan(8, -1, {$urandom, $urandom});
    ir_scan(4'hF, 0);
    dr_scan(4, -1, 64'b1101);
    ir_scan(4'h7, 0);
    dr_scan(6, -1, {$urandom, $urandom});
    ir_scan(4'h1, 2);
    dr_scan(40, 10, {$urandom, $urandom});

    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(4, 0))
        0: op = 4'h1;
        1: op = 4'h2;
        2: op = 4'hF;
        default: op = 4'($urandom);
      endcase
      ir_scan(op, $urandom_range(3, 0));
      ln = $urandom_range(40, 1);
      dr_scan(ln, $urandom_range(ln, 0), {$urandom, $urandom});
    end

    ir_scan(4'h2, 0);
    tick(1, 0); tick(0, 0); tick(0, 0);
    chk("tms_shdr", jt.STATE, 4'h3);
    for (int i = 0; i < 4; i++) tick(1, 0);
    chk("tms_ir_held", jt.IR, 4'h2);
    tick(1, 0);
    chk("tms_tlr", jt.STATE, 4'hF);
    chk("tms_ir_reload", jt.IR, RST_IR);
    chk("tms_user_sel", jt.USER_SEL, 1'b0);
    model_ir = RST_IR;
    tick(0, 0);

    ir_scan(4'h2, 0);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    chk("part_shir", jt.STATE, 4'hA);
    tick(0, 1); tick(0, 1);
    TRST = 1'b0;
    #2;
    chk("trst_state", jt.STATE, 4'hF);
    chk("trst_ir", jt.IR, RST_IR);
    chk("trst_oe", jt.TDO_OE, 1'b0);
    chk("trst_tdo", jt.TDO, 1'b0);
    @(negedge TCK); #1 TRST = 1'b1;
    tick(0, 0);
    model_ir = RST_IR;
    dr_scan(5, -1, {$urandom, $urandom});
    ir_scan(4'h2, 0);
    dr_scan(3, 1, {$urandom, $urandom});

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
